// File: rtl/ldmac_pkg.sv
// Shared types and helpers for the ldmac round-key addition stage.
package ldmac_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [5:0] RC_INIT_DEFAULT = 6'h01;
  localparam int         RC_MAXW         = 64;

  // Shift left by one within rcw bits, feeding back rc[rcw-1]^rc[rcw-2]^1.
  function automatic logic [RC_MAXW-1:0] rc_next(input logic [RC_MAXW-1:0] rc,
                                                 input int rcw);
    logic [RC_MAXW-1:0] mask;
    logic [RC_MAXW-1:0] res;
    mask   = (RC_MAXW'(1) << rcw) - RC_MAXW'(1);
    res    = (rc << 1) & mask;
    res[0] = rc[rcw-1] ^ rc[rcw-2] ^ 1'b1;
    return res;
  endfunction

  // Key word XORed into state word j (1 <= j <= nw-2).
  function automatic int key_idx(input int j, input int nw);
    return (2 * (j - 1)) % nw;
  endfunction

endpackage

// File: rtl/rc_lfsr.sv
// Round-constant register: loads the initial constant, advances once per accepted beat.
module rc_lfsr
  import ldmac_pkg::*;
#(
  parameter int RCW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [RCW-1:0] init,
  output logic [RCW-1:0] rc
);

  logic [RCW-1:0] rc_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rc_reg <= '0;
    end else if (load) begin
      rc_reg <= init;
    end else if (step) begin
      rc_reg <= RCW'(rc_next(RC_MAXW'(rc_reg), RCW));
    end
  end

  assign rc = rc_reg;

endmodule

// File: rtl/add_round_key_seq.sv
// Sequenced AddRoundKey stage: rotating key, LFSR round constant and a
// registered 1-deep valid/ready output slot.
module add_round_key_seq
  import ldmac_pkg::*;
#(
  parameter int             W        = 32,
  parameter int             NW       = 4,
  parameter int             RCW      = 6,
  parameter int             NROUNDS  = 32,
  parameter logic [RCW-1:0] RC_INIT  = RCW'(RC_INIT_DEFAULT),
  parameter bit             FLIP_MSB = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW*W-1:0] key,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW*W-1:0] in_state,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW*W-1:0] out_state,
  output logic          out_last,
  output logic [5:0]    out_round,
  output logic          busy
);

  localparam logic [W-1:0] FLIP_MASK = {FLIP_MSB, {(W-1){1'b0}}};

  state_t          state_reg, state_next;
  logic [W-1:0]    key_reg [NW];
  logic [5:0]      rnd_reg;
  logic [RCW-1:0]  rc;
  logic            accept;
  logic            last_rnd;
  logic [NW*W-1:0] b_state;

  logic            out_valid_reg;
  logic            out_last_reg;
  logic [5:0]      out_round_reg;
  logic [NW*W-1:0] out_state_reg;

  assign accept   = in_valid && in_ready;
  assign last_rnd = (rnd_reg == 6'(NROUNDS - 1));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state; start restarts the block from either state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (start) begin
          state_next = RUN;
        end else if (accept && last_rnd) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs; in_ready never depends on in_valid
  always_comb begin
    busy     = (state_reg == RUN);
    in_ready = busy && (!out_valid_reg || out_ready) && !start;
  end

  rc_lfsr #(
    .RCW (RCW)
  ) u_rc_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (start),
    .step (accept),
    .init (RC_INIT),
    .rc   (rc)
  );

  // Key rotates one word per accepted beat so round r sees K0[(i+r) mod NW]
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) key_reg[i] <= '0;
    end else if (start) begin
      for (int i = 0; i < NW; i++) key_reg[i] <= key[i*W +: W];
    end else if (accept) begin
      for (int i = 0; i < NW; i++) key_reg[i] <= key_reg[(i + 1) % NW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_reg <= '0;
    end else if (start) begin
      rnd_reg <= '0;
    end else if (accept) begin
      rnd_reg <= rnd_reg + 6'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NW; gi++) begin : g_word
      if (gi == 0) begin : g_pass
        assign b_state[gi*W +: W] = in_state[gi*W +: W];
      end else if (gi < NW - 1) begin : g_key
        localparam int KI = key_idx(gi, NW);
        assign b_state[gi*W +: W] = in_state[gi*W +: W] ^ key_reg[KI];
      end else begin : g_rc
        assign b_state[gi*W +: W] = in_state[gi*W +: W] ^ FLIP_MASK
                                    ^ {{(W-RCW){1'b0}}, rc};
      end
    end
  endgenerate

  // A drain and accept in the same cycle simply replaces the held beat
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      out_round_reg <= '0;
      out_state_reg <= '0;
    end else if (start) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_last_reg  <= last_rnd;
      out_round_reg <= rnd_reg;
      out_state_reg <= b_state;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_last  = out_last_reg;
  assign out_round = out_round_reg;
  assign out_state = out_state_reg;

endmodule

// File: tb/tb_add_round_key_seq.sv
// Bench for add_round_key_seq: three configurations driven in lockstep, a
// reference model checked every cycle, and literal expectations pinning it.
module tb_add_round_key_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, in_valid, out_ready;
  logic [159:0] in_state;
  logic [159:0] key_v [3];

  logic         g_ir [3];
  logic         g_ov [3];
  logic         g_last [3];
  logic         g_busy [3];
  logic [5:0]   g_round [3];
  logic [159:0] g_os [3];
  logic [127:0] os0, os1;
  logic [159:0] os2;

  assign g_os[0] = {32'b0, os0};
  assign g_os[1] = {32'b0, os1};
  assign g_os[2] = os2;

  add_round_key_seq #(.W(32), .NW(4), .RCW(6), .NROUNDS(4), .RC_INIT(6'h01), .FLIP_MSB(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .key(key_v[0][127:0]), .in_valid(in_valid),
    .in_ready(g_ir[0]), .in_state(in_state[127:0]), .out_valid(g_ov[0]), .out_ready(out_ready),
    .out_state(os0), .out_last(g_last[0]), .out_round(g_round[0]), .busy(g_busy[0]));

  add_round_key_seq #(.W(32), .NW(4), .RCW(6), .NROUNDS(9), .RC_INIT(6'h01), .FLIP_MSB(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .key(key_v[1][127:0]), .in_valid(in_valid),
    .in_ready(g_ir[1]), .in_state(in_state[127:0]), .out_valid(g_ov[1]), .out_ready(out_ready),
    .out_state(os1), .out_last(g_last[1]), .out_round(g_round[1]), .busy(g_busy[1]));

  add_round_key_seq #(.W(32), .NW(5), .RCW(6), .NROUNDS(4), .RC_INIT(6'h01), .FLIP_MSB(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start), .key(key_v[2]), .in_valid(in_valid),
    .in_ready(g_ir[2]), .in_state(in_state), .out_valid(g_ov[2]), .out_ready(out_ready),
    .out_state(os2), .out_last(g_last[2]), .out_round(g_round[2]), .busy(g_busy[2]));

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int inst, input logic [159:0] got,
                     input logic [159:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s inst%0d t=%0t got=%h expected=%h", name, inst, $time, got, exp);
  endtask

  function automatic int nw_of(input int i);
    return (i == 2) ? 5 : 4;
  endfunction
  function automatic int nr_of(input int i);
    return (i == 1) ? 9 : 4;
  endfunction
  function automatic bit flip_of(input int i);
    return (i != 2);
  endfunction

  // Round constant for round r: RC_INIT advanced r times by the feedback rule
  function automatic logic [5:0] rc_at(input int r);
    logic [5:0] v;
    v = 6'h01;
    for (int s = 0; s < r; s++) v = {v[4:0], v[5] ^ v[4] ^ 1'b1};
    return v;
  endfunction

  // Round r uses the master key rotated r words: K_r[i] = K0[(i+r) mod NW]
  function automatic logic [159:0] exp_beat(input int i, input logic [159:0] a,
                                            input logic [159:0] k0, input int r);
    logic [159:0] b;
    logic [31:0]  aw;
    int           nw;
    b  = '0;
    nw = nw_of(i);
    for (int j = 0; j < nw; j++) begin
      aw = a[j*32 +: 32];
      if (j == 0) b[j*32 +: 32] = aw;
      else if (j < nw - 1) b[j*32 +: 32] = aw ^ k0[(((2 * (j - 1)) % nw + r) % nw) * 32 +: 32];
      else b[j*32 +: 32] = aw ^ (flip_of(i) ? 32'h8000_0000 : 32'h0) ^ {26'b0, rc_at(r)};
    end
    return b;
  endfunction

  function automatic logic [31:0] wd(input int i, input int j);
    return g_os[i][j*32 +: 32];
  endfunction

  function automatic logic [31:0] rc_tab(input int n);
    case (n)
      0: return 32'h01;
      1: return 32'h03;
      2: return 32'h07;
      default: return 32'h0F;
    endcase
  endfunction

  logic         m_busy [3];
  int           m_rnd [3];
  logic [159:0] m_k0 [3];
  logic         m_ov [3];
  logic [159:0] m_os [3];
  logic         m_last [3];
  logic [5:0]   m_round [3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic rdy;
      if (rst) begin
        m_busy[i] = 1'b0; m_rnd[i] = 0; m_ov[i] = 1'b0;
        m_os[i] = '0; m_last[i] = 1'b0; m_round[i] = '0;
      end else begin
        rdy = m_busy[i] && (!m_ov[i] || out_ready) && !start;
        if (start) begin
          m_busy[i] = 1'b1; m_rnd[i] = 0; m_k0[i] = key_v[i]; m_ov[i] = 1'b0;
        end else if (in_valid && rdy) begin
          m_os[i]    = exp_beat(i, in_state, m_k0[i], m_rnd[i]);
          m_ov[i]    = 1'b1;
          m_last[i]  = (m_rnd[i] == nr_of(i) - 1);
          m_round[i] = 6'(m_rnd[i]);
          m_rnd[i]++;
          if (m_last[i]) m_busy[i] = 1'b0;
        end else if (out_ready) begin
          m_ov[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic exp_ir;
      exp_ir = m_busy[i] && (!m_ov[i] || out_ready) && !start;
      chk("in_ready", i, 160'(g_ir[i]), 160'(exp_ir));
      chk("busy", i, 160'(g_busy[i]), 160'(m_busy[i]));
      chk("out_valid", i, 160'(g_ov[i]), 160'(m_ov[i]));
      chk("out_last", i, 160'(g_last[i]), 160'(m_last[i]));
      chk("out_round", i, 160'(g_round[i]), 160'(m_round[i]));
      chk("out_state", i, g_os[i], m_os[i]);
      if (g_ov[i] && out_ready)
        $display("inst%0d beat round=%0d last=%0d state=%h", i, g_round[i], g_last[i], g_os[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
    for (int i = 0; i < 3; i++) key_v[i] = '0;
    step(); step();
    chk("rst_out_valid", 0, 160'(g_ov[0]), 160'(0));
    chk("rst_busy", 0, 160'(g_busy[0]), 160'(0));
    chk("rst_in_ready", 0, 160'(g_ir[0]), 160'(0));
    chk("rst_out_state", 0, g_os[0], 160'(0));
    chk("rst_out_round", 0, 160'(g_round[0]), 160'(0));

    // Block 1: key {4,3,2,1} (NW=5: {5,4,3,2,1}), zero states, every cycle
    rst = 1'b0;
    key_v[0] = {32'd0, 32'd4, 32'd3, 32'd2, 32'd1};
    key_v[1] = key_v[0];
    key_v[2] = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    #1;
    chk("busy_rise", 0, 160'(g_busy[0]), 160'(1));
    chk("in_ready_run", 0, 160'(g_ir[0]), 160'(1));
    for (int n = 0; n < 9; n++) begin
      step();
      if (n < 4) begin
        chk("w1", 0, 160'(wd(0, 1)), 160'(n + 1));
        chk("w2", 0, 160'(wd(0, 2)), 160'(((n + 2) % 4) + 1));
        chk("w3", 0, 160'(wd(0, 3)), 160'(32'h8000_0000 | rc_tab(n)));
        chk("last", 0, 160'(g_last[0]), 160'(n == 3));
        chk("busy_fall", 0, 160'(g_busy[0]), 160'(n != 3));
      end
      if (n < 2) begin
        chk("nw5_w3", 2, 160'(wd(2, 3)), 160'((n == 0) ? 5 : 1));
        chk("nw5_w4", 2, 160'(wd(2, 4)), 160'(rc_tab(n)));
      end
      if (n == 8) begin
        chk("r9_rc", 1, 160'(wd(1, 3) & 32'h3F), 160'(32'h37));
        chk("r9_last", 1, 160'(g_last[1]), 160'(1));
        chk("r9_round", 1, 160'(g_round[1]), 160'(8));
      end
    end

    // Backpressure after the first result
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("bp_w3", 0, 160'(wd(0, 3)), 160'(32'h8000_0001));
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready", 0, 160'(g_ir[0]), 160'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_hold_w3", 0, 160'(wd(0, 3)), 160'(32'h8000_0001));
      chk("bp_hold_valid", 0, 160'(g_ov[0]), 160'(1));
      chk("bp_hold_round", 0, 160'(g_round[0]), 160'(0));
    end
    out_ready = 1'b1;
    step();
    chk("bp_rel_w3", 0, 160'(wd(0, 3)), 160'(32'h8000_0003));
    chk("bp_rel_w1", 0, 160'(wd(0, 1)), 160'(2));
    chk("bp_rel_round", 0, 160'(g_round[0]), 160'(1));

    // Restart at round 2 with a beat offered
    key_v[0] = {32'd0, 32'd8, 32'd7, 32'd6, 32'd5};
    key_v[1] = key_v[0];
    key_v[2] = {32'd10, 32'd9, 32'd8, 32'd7, 32'd6};
    start = 1'b1;
    #1;
    chk("abort_in_ready", 0, 160'(g_ir[0]), 160'(0));
    step();
    start = 1'b0;
    chk("abort_valid", 0, 160'(g_ov[0]), 160'(0));
    chk("abort_busy", 0, 160'(g_busy[0]), 160'(1));
    step();
    chk("new_round", 0, 160'(g_round[0]), 160'(0));
    chk("new_w1", 0, 160'(wd(0, 1)), 160'(5));
    chk("new_w2", 0, 160'(wd(0, 2)), 160'(7));
    chk("new_w3", 0, 160'(wd(0, 3)), 160'(32'h8000_0001));

    // Reset mid-block with a pending beat
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rrst_valid", 0, 160'(g_ov[0]), 160'(0));
    chk("rrst_state", 0, g_os[0], 160'(0));
    chk("rrst_busy", 0, 160'(g_busy[0]), 160'(0));
    chk("rrst_last", 0, 160'(g_last[0]), 160'(0));
    chk("rrst_round", 0, 160'(g_round[0]), 160'(0));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("idle_ignore_valid", 0, 160'(g_ov[0]), 160'(0));
      chk("idle_ignore_busy", 0, 160'(g_busy[0]), 160'(0));
    end

    // Random states, stalls and a restart, checked by the model
    for (int c = 0; c < 80; c++) begin
      start = (c == 0 || c == 40);
      if (start) begin
        for (int i = 0; i < 3; i++) key_v[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_state  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      step();
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/add_round_key_seq.md
# add_round_key_seq

Sequenced, parametrised round-key addition stage for the Pelican/ldmac permutation datapath. It loads a master key once per message block, then applies one AddRoundKey per accepted state beat over `NROUNDS` rounds. Round constants come from an internal 6-bit LFSR, and the key rotates by one word per round. It sits between the round function (SubCells/MixColumns stages) and the state register, and provides a registered 1-cycle valid/ready pipeline stage.

## Interface
- `W`, 32: word width in bits.
- `NW`, 4: state words per beat; `NW >= 3`.
- `RCW`, 6: round-constant width; `RCW <= W-1`, `RCW >= 2`.
- `NROUNDS`, 32: rounds per block, 1..64.
- `RC_INIT`, 6'h01: constant used in round 0.
- `FLIP_MSB`, 1: when 1, invert bit `W-1` of word `NW-1` every round.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  1-cycle pulse; loads `key` and restarts the round sequence.
- `key`  in  NW*W  master key, word i at bits `[i*W +: W]`; sampled only on `start`.
- `in_valid`  in  1  input state beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `in_state`  in  NW*W  state words `a[0..NW-1]`.
- `out_valid`  out  1  registered result valid.
- `out_ready`  in  1  downstream accepts.
- `out_state`  out  NW*W  result words `b[0..NW-1]`.
- `out_last`  out  1  beat is round `NROUNDS-1`.
- `out_round`  out  6  round index of the beat.
- `busy`  out  1  FSM in RUN.

## Operation
- FSM states:
  - IDLE: on `start`, load `K <= key`, `rc <= RC_INIT`, `rnd <= 0`, go to RUN.
  - RUN: accepts beats. On accepting round `NROUNDS-1`, go to IDLE.
- Accept condition: `in_valid && in_ready`, where `in_ready = busy && (!out_valid || out_ready)`.
- Per accepted beat, with current round r, K and rc:
  - `b[0] = a[0]`.
  - `b[j] = a[j] ^ K[(2*(j-1)) mod NW]` for `1 <= j <= NW-2`.
  - `b[NW-1] = a[NW-1]`, with bit `W-1` inverted if `FLIP_MSB`, and bits `[RCW-1:0]` XORed with rc.
  - For NW=4 this gives words 1 and 2 XORed with K[0] and K[2].
- After each accept:
  - `K[i] <= K[(i+1) mod NW]` (rotate by one word).
  - `rc <= {rc[RCW-2:0], rc[RCW-1]^rc[RCW-2]^1'b1}`.
  - `rnd <= rnd+1`.
  - `out_last <= (rnd == NROUNDS-1)`.
  - `out_round <= rnd`.
- rc sequence from 01: 01, 03, 07, 0F, 1F, 3E, 3D, 3B, 37, …
- Output register: loads on accept and sets `out_valid`. It clears `out_valid` when `out_ready` is high and no new accept occurs in the same cycle. A simultaneous drain and accept replaces the held beat, so 1 beat/cycle throughput is sustained.
- `start` in RUN aborts the current block and restarts as from IDLE:
  - `out_valid` is cleared in the same edge.
  - any same-cycle input beat is not accepted (`in_ready` is forced 0 while `start`).
- `start` in IDLE while `out_valid` is high: the pending beat is discarded.
- `in_valid` while IDLE is ignored and never accepted.
- Reset: state IDLE.
  - All outputs zero: `in_ready`, `out_valid`, `out_last`, `busy`, `out_round`, `out_state`.
  - `K`, `rc` and `rnd` are zero.
  - Reset overrides `start`.

## Timing
- Latency: an input accepted at edge n appears on `out_state` after edge n (1 cycle).
- `busy` rises on the edge after `start` and falls on the edge that accepts the last round.
- `in_ready` is combinational from `busy`, `out_valid`, `out_ready` and `start`. No combinational path from `in_valid` to `in_ready`.
- `out_*` are registered only; they stay stable while `out_valid && !out_ready`.
- The final beat may remain pending in IDLE until drained.

## Structure
- Shared package `ldmac_pkg` holds:
  - FSM state enum (IDLE, RUN).
  - `RC_INIT` default.
  - function `rc_next(rc)`.
  - helper `key_idx(j, NW)`.
- One sub-module, `rc_lfsr` (ports `clk`, `rst`, `load`, `step`, `init`, `rc`), holds the round-constant register.
- Key rotation, datapath XORs, round counter and output register stay in the top module.

## Test plan
- NW=4, W=32, NROUNDS=4, key = {K3..K0} = {4,3,2,1}, start, all-zero states, `out_ready=1`, input every cycle -> 4 consecutive outputs:
  - word1 = 1,2,3,4
  - word2 = 3,4,1,2
  - word3 = 80000001, 80000003, 80000007, 8000000F
  - `out_last` only on the 4th; `busy` drops on the edge accepting the 4th.
- Backpressure: hold `out_ready=0` for 3 cycles after the first result -> `out_state` stable, `in_ready=0`, no round skipped. Release -> next rc = 03.
- NROUNDS=9 -> the 9th output's low 6 bits of word3 = 37.
- `start` asserted mid-block at round 2 with `in_valid` high -> beat not accepted, `out_valid=0` next cycle, next accepted beat uses rc=01 and the new key.
- `rst` during RUN with `out_valid=1` -> the next cycle has all outputs 0 and state IDLE; `in_valid` is then ignored until `start`.
- FLIP_MSB=0, NW=5 -> word3 uses K[4], then K[0]; bit 31 of word4 unchanged.
